// File: rtl/read_data_mux_pkg.sv
// ============================================================================
// read_mux_pkg
// Shared definitions for the read-side data mux: source encodings for the
// select pipeline, the pipeline entry type and the address-select priority
// encoder.
// ============================================================================
package read_mux_pkg;

    // Source codes carried through the select pipeline
    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_DMEM = 2'd1;
    localparam logic [1:0] SRC_IMEM = 2'd2;
    localparam logic [1:0] SRC_SW   = 2'd3;

    // One slot of the select pipeline
    typedef struct packed {
        logic       valid;
        logic [1:0] src;
    } pipe_entry_t;

    // Switch peripheral wins over data memory, data memory over instruction
    // memory; no select at all means the read hit nothing.
    function automatic logic [1:0] encodeSrc(
        input logic selSwitch,
        input logic selDataMem,
        input logic selInstMem
    );
        logic [1:0] src;
        src = SRC_NONE;
        if (selSwitch) begin
            src = SRC_SW;
        end else if (selDataMem) begin
            src = SRC_DMEM;
        end else if (selInstMem) begin
            src = SRC_IMEM;
        end
        return src;
    endfunction

endpackage

// File: rtl/read_data_mux_switch_debouncer.sv
// ============================================================================
// switch_debouncer
// Synchronizes the asynchronous board switches with two flops and only
// accepts a new value once it has been stable for DEBOUNCE_CYCLES
// consecutive synchronized samples.
//
// Ports
//   clk       in   1         system clock, rising edge
//   rst_n     in   1         asynchronous reset, active low
//   i_raw     in   SW_WIDTH  asynchronous switch inputs
//   o_stable  out  SW_WIDTH  debounced switch value
// ============================================================================
module switch_debouncer #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SW_WIDTH-1:0] i_raw,
    output logic [SW_WIDTH-1:0] o_stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SW_WIDTH-1:0] r_sync1;
    logic [SW_WIDTH-1:0] r_sync2;
    logic [SW_WIDTH-1:0] r_syncPrev;
    logic [SW_WIDTH-1:0] r_stable;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       w_countNext;
    logic                w_restart;

    // A change between consecutive samples restarts the stability window;
    // so does agreement with the accepted value, since there is nothing to
    // accept in that case.
    assign w_restart   = (r_sync2 != r_syncPrev) || (r_sync2 == r_stable);
    assign w_countNext = (r_count == CW'(DEBOUNCE_CYCLES)) ? r_count : r_count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_syncPrev <= '0;
            r_stable   <= '0;
            r_count    <= '0;
        end else begin
            r_sync1    <= i_raw;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            if (w_restart) begin
                r_count <= '0;
            end else begin
                r_count <= w_countNext;
                // Accept on the edge where the counter reaches DEBOUNCE_CYCLES-1;
                // the restart that follows keeps the counter from going further.
                if (w_countNext == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_stable <= r_sync2;
                end
            end
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/read_data_mux.sv
// ============================================================================
// read_data_mux
// Read-side counterpart of the memory-mapped write demux. Steers read data
// from data memory, instruction memory or the debounced board switches back
// to the CPU load path, and flags reads that decode to no device.
//
// Ports
//   clk             in   1           system clock, rising edge
//   rst_n           in   1           asynchronous reset, active low
//   i_readEnable    in   1           CPU issues a read this cycle
//   i_selDataMem    in   1           address decodes to data memory
//   i_selInstMem    in   1           address decodes to instruction memory
//   i_selSwitch     in   1           address decodes to switch peripheral
//   i_dataMemRdata  in   DATA_WIDTH  data memory read port
//   i_instMemRdata  in   DATA_WIDTH  instruction memory read port
//   i_switchesRaw   in   SW_WIDTH    asynchronous board switches
//   o_readData      out  DATA_WIDTH  returned read data, held between responses
//   o_readValid     out  1           one-cycle pulse, response valid
//   o_readError     out  1           qualifies o_readValid: read hit no device
//   o_switchState   out  SW_WIDTH    current debounced switch value
// ============================================================================
module read_data_mux
    import read_mux_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SW_WIDTH        = 16,
    parameter int MEM_LATENCY     = 1,   // 1 or 2
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_readEnable,
    input  logic                  i_selDataMem,
    input  logic                  i_selInstMem,
    input  logic                  i_selSwitch,
    input  logic [DATA_WIDTH-1:0] i_dataMemRdata,
    input  logic [DATA_WIDTH-1:0] i_instMemRdata,
    input  logic [SW_WIDTH-1:0]   i_switchesRaw,
    output logic [DATA_WIDTH-1:0] o_readData,
    output logic                  o_readValid,
    output logic                  o_readError,
    output logic [SW_WIDTH-1:0]   o_switchState
);

    pipe_entry_t           r_pipe [MEM_LATENCY];
    pipe_entry_t           w_issue;
    pipe_entry_t           w_resp;
    logic [SW_WIDTH-1:0]   w_switchState;
    logic [DATA_WIDTH-1:0] w_switchExt;
    logic [DATA_WIDTH-1:0] r_readData;
    logic                  r_readValid;
    logic                  r_readError;

    switch_debouncer #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_raw    (i_switchesRaw),
        .o_stable (w_switchState)
    );

    always_comb begin
        w_issue       = '0;
        w_issue.valid = i_readEnable;
        w_issue.src   = encodeSrc(i_selSwitch, i_selDataMem, i_selInstMem);
    end

    // Zero-extend the switches; written this way so DATA_WIDTH == SW_WIDTH
    // does not need a zero-width replication.
    always_comb begin
        w_switchExt                 = '0;
        w_switchExt[SW_WIDTH-1:0]   = w_switchState;
    end

    // Select pipeline: one slot per cycle of memory latency, so the tail
    // lines up with the cycle the memory presents its data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_issue;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_resp = r_pipe[MEM_LATENCY-1];

    // Registered response. The switch source takes the debounced value as
    // it stands before this edge, so an accept on the same edge is not seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_readData  <= '0;
            r_readValid <= 1'b0;
            r_readError <= 1'b0;
        end else begin
            r_readValid <= w_resp.valid;
            r_readError <= 1'b0;
            if (w_resp.valid) begin
                case (w_resp.src)
                    SRC_DMEM: r_readData <= i_dataMemRdata;
                    SRC_IMEM: r_readData <= i_instMemRdata;
                    SRC_SW:   r_readData <= w_switchExt;
                    default: begin
                        r_readData  <= '0;
                        r_readError <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_readData    = r_readData;
    assign o_readValid   = r_readValid;
    assign o_readError   = r_readError;
    assign o_switchState = w_switchState;

endmodule

// File: tb/tb_read_data_mux.sv
// ============================================================================
// tb_read_data_mux
// Directed scenarios plus randomized traffic against a behavioural model of
// the read mux. The model treats a read as a queue of pending requests
// answered MEM_LATENCY edges later, and the debouncer as "the last
// DEBOUNCE_CYCLES synchronized samples all agree on a new value".
// ============================================================================
module tb_read_data_mux;

    localparam int DW  = 32;
    localparam int SW  = 16;
    localparam int LAT = 1;
    localparam int DEB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          readEnable;
    logic          selDataMem;
    logic          selInstMem;
    logic          selSwitch;
    logic [DW-1:0] dataMemRdata;
    logic [DW-1:0] instMemRdata;
    logic [SW-1:0] switchesRaw;
    logic [DW-1:0] readData;
    logic          readValid;
    logic          readError;
    logic [SW-1:0] switchState;

    always #5 clk = ~clk;

    read_data_mux #(
        .DATA_WIDTH      (DW),
        .SW_WIDTH        (SW),
        .MEM_LATENCY     (LAT),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_readEnable   (readEnable),
        .i_selDataMem   (selDataMem),
        .i_selInstMem   (selInstMem),
        .i_selSwitch    (selSwitch),
        .i_dataMemRdata (dataMemRdata),
        .i_instMemRdata (instMemRdata),
        .i_switchesRaw  (switchesRaw),
        .o_readData     (readData),
        .o_readValid    (readValid),
        .o_readError    (readError),
        .o_switchState  (switchState)
    );

    int   total   = 0;
    int   bad     = 0;
    logic checkEn = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Request kinds: 0 = unmapped, 1 = data memory, 2 = instruction memory, 3 = switches
    typedef struct {
        logic v;
        int   kind;
    } req_t;

    req_t          pendQ[$];
    logic [SW-1:0] rawHist[$];
    req_t          mHead;
    bit            mRun;
    logic [DW-1:0] expData;
    logic          expValid;
    logic          expError;
    logic [SW-1:0] expSw;

    function automatic int kindOf(input logic sw, input logic dm, input logic im);
        if (sw) return 3;
        if (dm) return 1;
        if (im) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendQ.delete();
            for (int i = 0; i < LAT; i++) pendQ.push_back('{1'b0, 0});
            rawHist.delete();
            for (int i = 0; i < DEB + 2; i++) rawHist.push_back('0);
            expData  = '0;
            expValid = 1'b0;
            expError = 1'b0;
            expSw    = '0;
        end else begin
            // answer the request issued LAT edges ago, using the old switch value
            mHead    = pendQ.pop_front();
            expValid = mHead.v;
            expError = 1'b0;
            if (mHead.v) begin
                case (mHead.kind)
                    1: expData = dataMemRdata;
                    2: expData = instMemRdata;
                    3: expData = {{(DW-SW){1'b0}}, expSw};
                    default: begin
                        expData  = '0;
                        expError = 1'b1;
                    end
                endcase
            end
            pendQ.push_back('{readEnable, kindOf(selSwitch, selDataMem, selInstMem)});
            // rawHist[DEB+1] is the raw value at this edge; two sync stages mean
            // entries [0..DEB-1] are the synchronized samples that matter now.
            rawHist.push_back(switchesRaw);
            if (rawHist.size() > DEB + 2) void'(rawHist.pop_front());
            mRun = 1'b1;
            for (int i = 1; i < DEB; i++) begin
                if (rawHist[i] != rawHist[0]) mRun = 1'b0;
            end
            if (mRun && rawHist[0] != expSw) expSw = rawHist[0];
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            checkOutput("model.readValid", {31'b0, readValid}, {31'b0, expValid});
            checkOutput("model.readError", {31'b0, readError}, {31'b0, expError});
            checkOutput("model.readData", readData, expData);
            checkOutput("model.switchState", {16'b0, switchState}, {16'b0, expSw});
        end
    end

    // Drive one cycle of inputs and return on the following falling edge
    task automatic applyStimulus(input logic re, input logic sd, input logic si, input logic ss,
                                 input logic [DW-1:0] dm, input logic [DW-1:0] im,
                                 input logic [SW-1:0] sw);
        readEnable   = re;
        selDataMem   = sd;
        selInstMem   = si;
        selSwitch    = ss;
        dataMemRdata = dm;
        instMemRdata = im;
        switchesRaw  = sw;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        // 1. reset, with a read request held during reset
        repeat (3) applyStimulus(1, 1, 0, 0, 32'h5A5A5A5A, 32'h0, 16'h0);
        checkOutput("reset.readValid", {31'b0, readValid}, 32'h0);
        checkOutput("reset.readError", {31'b0, readError}, 32'h0);
        checkOutput("reset.readData", readData, 32'h0);
        checkOutput("reset.switchState", {16'b0, switchState}, 32'h0);
        rst_n   = 1'b1;
        checkEn = 1'b1;
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h0);
        // read in flight when reset hits must vanish
        applyStimulus(1, 1, 0, 0, 32'h5A5A5A5A, 32'h0, 16'h0);
        rst_n = 1'b0;
        applyStimulus(1, 1, 0, 0, 32'h5A5A5A5A, 32'h0, 16'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h5A5A5A5A, 32'h0, 16'h0);
            checkOutput("flush.readValid", {31'b0, readValid}, 32'h0);
            checkOutput("flush.readData", readData, 32'h0);
        end

        // 2. back-to-back DMEM, IMEM, DMEM
        applyStimulus(1, 1, 0, 0, 32'h0, 32'h0, 16'h0);
        applyStimulus(1, 0, 1, 0, 32'h11111111, 32'h0, 16'h0);
        checkOutput("b2b.valid0", {31'b0, readValid}, 32'h1);
        checkOutput("b2b.data0", readData, 32'h11111111);
        applyStimulus(1, 1, 0, 0, 32'h0, 32'h22222222, 16'h0);
        checkOutput("b2b.valid1", {31'b0, readValid}, 32'h1);
        checkOutput("b2b.data1", readData, 32'h22222222);
        applyStimulus(0, 0, 0, 0, 32'h33333333, 32'h0, 16'h0);
        checkOutput("b2b.valid2", {31'b0, readValid}, 32'h1);
        checkOutput("b2b.data2", readData, 32'h33333333);
        checkOutput("b2b.error2", {31'b0, readError}, 32'h0);

        // 3. unmapped read
        applyStimulus(1, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0);
        applyStimulus(0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0);
        checkOutput("unmapped.valid", {31'b0, readValid}, 32'h1);
        checkOutput("unmapped.error", {31'b0, readError}, 32'h1);
        checkOutput("unmapped.data", readData, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'h0);
        checkOutput("unmapped.idleValid", {31'b0, readValid}, 32'h0);
        checkOutput("unmapped.idleError", {31'b0, readError}, 32'h0);
        checkOutput("unmapped.held", readData, 32'h0);

        // 4. priority: switches beat data memory
        repeat (8) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00A5);
        checkOutput("prio.switchState", {16'b0, switchState}, 32'h000000A5);
        applyStimulus(1, 1, 0, 1, 32'hDEADBEEF, 32'h0, 16'h00A5);
        applyStimulus(0, 0, 0, 0, 32'hDEADBEEF, 32'h0, 16'h00A5);
        checkOutput("prio.valid", {31'b0, readValid}, 32'h1);
        checkOutput("prio.data", readData, 32'h000000A5);
        checkOutput("prio.error", {31'b0, readError}, 32'h0);

        // 5. debounce: 3-cycle glitch rejected
        repeat (8) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h0000);
        checkOutput("deb.base", {16'b0, switchState}, 32'h0);
        repeat (3) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00FF);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h0000);
            checkOutput("deb.glitch", {16'b0, switchState}, 32'h0);
        end
        // held change accepted on edge 6; 6. switch read issued on edge 5
        repeat (4) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00FF);
        applyStimulus(1, 0, 0, 1, 32'h0, 32'h0, 16'h00FF);
        checkOutput("deb.edge5", {16'b0, switchState}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00FF);
        checkOutput("deb.edge6", {16'b0, switchState}, 32'h000000FF);
        checkOutput("swAccept.valid", {31'b0, readValid}, 32'h1);
        checkOutput("swAccept.oldData", readData, 32'h0);
        applyStimulus(1, 0, 0, 1, 32'h0, 32'h0, 16'h00FF);
        applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00FF);
        checkOutput("swAccept.newData", readData, 32'h000000FF);
        repeat (2) applyStimulus(0, 0, 0, 0, 32'h0, 32'h0, 16'h00FF);

        // randomized traffic, checked every cycle by the model
        begin
            logic [SW-1:0] rawNow;
            rawNow = 16'h00FF;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) rawNow = SW'($urandom);
                applyStimulus(($urandom_range(0, 3) != 0),
                              1'($urandom), 1'($urandom), 1'($urandom),
                              $urandom, $urandom, rawNow);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
